rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Upstream feeder for the SDRAM controller's ROM and BSRAM_IO toggle-handshake ports.
- Takes the byte-wide ioctl download stream from the HPS/firmware side and packs bytes into 16-bit little-endian words.
- Issues one ROM write per word, backpressuring the stream with ioctl_wait while each write is outstanding.
- After download it optionally fills battery-save RAM with a constant through the bsram_io port, then reports the loaded size.

Parameters:
- CLEAR_WORDS, 16384, number of 16-bit BSRAM words filled after download (word addresses 0..CLEAR_WORDS-1).
- CLEAR_FILL, 16'hFFFF, word written during the BSRAM fill.
- PAD_BYTE, 8'h00, high byte used when the download length is odd.

Ports:
- clk  in  1  SDRAM clock, same domain as the controller.
- init_n  in  1  synchronous active-low reset.
- ioctl_download  in  1  high while a ROM download is active.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  24  byte address of ioctl_dout.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  stall request to the ioctl source.
- clear_en  in  1  enable BSRAM fill after download (sampled at download end).
- rom_addr  out  23  word address [23:1].
- rom_din  out  16  write data.
- rom_we  out  1  always 1 while a request is pending.
- rom_req  out  1  request toggle.
- rom_req_ack  in  1  ack toggle from controller.
- bsram_io_addr  out  19  word address [19:1].
- bsram_io_din  out  16  fill data.
- bsram_io_we  out  1  write enable.
- bsram_io_req  out  1  request toggle.
- bsram_io_req_ack  in  1  ack toggle.
- busy  out  1  high in any state other than IDLE/DONE.
- done  out  1  one-cycle pulse on entry to DONE.
- rom_size  out  24  bytes loaded = highest ioctl_addr + 1.

Behaviour:
- Reset (init_n low at a clk edge):
  - state = IDLE; ioctl_wait = 0, busy = 0, done = 0, rom_size = 0.
  - rom_we = 0, bsram_io_we = 0; rom_addr, rom_din, bsram_io_addr, bsram_io_din = 0.
  - rom_req <= rom_req_ack and bsram_io_req <= bsram_io_req_ack. The controller's acks are not reset, so copying them guarantees no spurious request.
  - A reset mid-handshake abandons that transfer; the SDRAM may or may not receive the write.
- Handshake rule: a request is pending while req != ack. Issue by toggling req together with valid addr/din/we. Addr/din/we are held stable until ack == req. Never toggle req while a request is pending.
- States:
  - IDLE: on rising edge of ioctl_download (registered previous value) -> COLLECT; rom_size cleared.
  - COLLECT:
    - On ioctl_wr with ioctl_addr[0] = 0: latch the byte as low byte, set a half flag.
    - On ioctl_wr with ioctl_addr[0] = 1: rom_din = {byte, low byte, or PAD_BYTE if half flag clear}, rom_addr = ioctl_addr[23:1], toggle rom_req, ioctl_wait = 1 on the next cycle, -> WRITE_ROM.
    - rom_size = max(rom_size, ioctl_addr + 1) on every accepted strobe.
    - On falling edge of ioctl_download: -> FLUSH if half flag set, else -> CLEAR if clear_en, else -> DONE.
  - WRITE_ROM: wait for rom_req_ack == rom_req. Then ioctl_wait = 0, clear half flag, -> COLLECT.
  - FLUSH: write {PAD_BYTE, low byte} to the word of the last even address. Wait for ack, then -> CLEAR or DONE as above.
  - CLEAR: bsram_io_addr = word count, bsram_io_din = CLEAR_FILL, bsram_io_we = 1, toggle bsram_io_req, -> CLEAR_WAIT.
  - CLEAR_WAIT: on ack:
    - if bsram_io_addr == CLEAR_WORDS-1 -> DONE;
    - else increment bsram_io_addr (19-bit, no wrap expected) -> CLEAR.
  - DONE: done pulses for one cycle on entry. Stays in DONE; rom_size is held. A rising edge of ioctl_download -> COLLECT.
- Throughput and timing:
  - ioctl_wait is registered and asserted the cycle after the odd byte is accepted.
  - The ioctl source must leave at least 2 clk between strobes and honour ioctl_wait before its next strobe.
  - An ioctl_wr arriving in WRITE_ROM/FLUSH is a protocol violation and is dropped.
- Simultaneous events:
  - ioctl_wr in the same cycle as the download falling edge: the byte is processed first and the falling edge is recognised once back in COLLECT. The falling edge is held in a pending flag.
  - Download rising edge during CLEAR/CLEAR_WAIT: the current bsram_io handshake completes, the fill aborts, -> COLLECT.
- Odd-length writes: a download with no even byte before an odd byte uses PAD_BYTE as the low byte.
- Bytes are written in arrival order; ioctl_addr is not required to be monotonic.
- Write latency: req toggle one clk after the odd strobe; ioctl_wait release one clk after ack matches.

Test Plan:
- Reset with rom_req_ack = 1, bsram_io_req_ack = 0 -> after reset rom_req = 1, bsram_io_req = 0, and no ack changes for 100 clk.
- Download bytes 0x11,0x22,0x33,0x44 at addr 0..3, model ack after 6 clk, clear_en = 0 -> two ROM writes:
  - rom_addr 0 din 16'h2211, then rom_addr 1 din 16'h4433;
  - ioctl_wait high from strobe+1 until ack;
  - done pulse; rom_size = 4.
- Odd length: 3 bytes 0xAA,0xBB,0xCC -> writes 16'hBBAA @0 and 16'h00CC @1 (FLUSH); rom_size = 3.
- clear_en = 1, CLEAR_WORDS = 4 -> four bsram_io writes of 16'hFFFF at addr 0,1,2,3, each req toggled only after the prior ack; then done.
- Download rising edge during a fill at addr 2 with ack delayed 10 clk -> the addr-2 write completes, no addr-3 write, state COLLECT, rom_size = 0.
- init_n low while in WRITE_ROM -> next cycle ioctl_wait = 0, busy = 0, rom_req equals rom_req_ack.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: packs the ioctl byte stream into 16-bit ROM writes over a
// toggle handshake, then optionally fills BSRAM with a constant word.
module rom_loader #(
  parameter int unsigned CLEAR_WORDS = 16384,
  parameter logic [15:0] CLEAR_FILL  = 16'hFFFF,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [23:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        clear_en,
  output logic [22:0] rom_addr,
  output logic [15:0] rom_din,
  output logic        rom_we,
  output logic        rom_req,
  input  logic        rom_req_ack,
  output logic [18:0] bsram_io_addr,
  output logic [15:0] bsram_io_din,
  output logic        bsram_io_we,
  output logic        bsram_io_req,
  input  logic        bsram_io_req_ack,
  output logic        busy,
  output logic        done,
  output logic [23:0] rom_size
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE_ROM,
    S_FLUSH,
    S_CLEAR,
    S_CLEAR_WAIT,
    S_DONE
  } state_t;

  localparam logic [18:0] LAST_WORD = 19'(CLEAR_WORDS - 1);

  state_t      state_q, state_d;
  logic        dl_q, dl_d;
  logic        half_q, half_d;
  logic [7:0]  low_q, low_d;
  logic        fall_pend_q, fall_pend_d;
  logic        clr_q, clr_d;
  logic        abort_q, abort_d;
  logic [23:0] size_q, size_d;
  logic [22:0] rom_addr_q, rom_addr_d;
  logic [15:0] rom_din_q, rom_din_d;
  logic        rom_we_q, rom_we_d;
  logic        rom_req_q, rom_req_d;
  logic [18:0] bs_addr_q, bs_addr_d;
  logic [15:0] bs_din_q, bs_din_d;
  logic        bs_we_q, bs_we_d;
  logic        bs_req_q, bs_req_d;
  logic        wait_q, wait_d;
  logic        done_q, done_d;

  logic        rise, fall;
  logic        rom_idle, bs_idle;
  logic [23:0] size_cand, size_max;

  assign rise      = ioctl_download & ~dl_q;
  assign fall      = ~ioctl_download & dl_q;
  assign rom_idle  = (rom_req_q == rom_req_ack);
  assign bs_idle   = (bs_req_q == bsram_io_req_ack);
  assign size_cand = ioctl_addr + 24'd1;
  assign size_max  = (size_cand > size_q) ? size_cand : size_q;

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b0;
      half_q      <= 1'b0;
      low_q       <= 8'h00;
      fall_pend_q <= 1'b0;
      clr_q       <= 1'b0;
      abort_q     <= 1'b0;
      size_q      <= 24'h0;
      rom_addr_q  <= 23'h0;
      rom_din_q   <= 16'h0;
      rom_we_q    <= 1'b0;
      rom_req_q   <= rom_req_ack;
      bs_addr_q   <= 19'h0;
      bs_din_q    <= 16'h0;
      bs_we_q     <= 1'b0;
      bs_req_q    <= bsram_io_req_ack;
      wait_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      half_q      <= half_d;
      low_q       <= low_d;
      fall_pend_q <= fall_pend_d;
      clr_q       <= clr_d;
      abort_q     <= abort_d;
      size_q      <= size_d;
      rom_addr_q  <= rom_addr_d;
      rom_din_q   <= rom_din_d;
      rom_we_q    <= rom_we_d;
      rom_req_q   <= rom_req_d;
      bs_addr_q   <= bs_addr_d;
      bs_din_q    <= bs_din_d;
      bs_we_q     <= bs_we_d;
      bs_req_q    <= bs_req_d;
      wait_q      <= wait_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dl_d        = ioctl_download;
    half_d      = half_q;
    low_d       = low_q;
    fall_pend_d = fall_pend_q;
    clr_d       = clr_q;
    abort_d     = abort_q;
    size_d      = size_q;
    rom_addr_d  = rom_addr_q;
    rom_din_d   = rom_din_q;
    rom_we_d    = rom_we_q;
    rom_req_d   = rom_req_q;
    bs_addr_d   = bs_addr_q;
    bs_din_d    = bs_din_q;
    bs_we_d     = bs_we_q;
    bs_req_d    = bs_req_q;
    wait_d      = wait_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (rise) begin
          state_d     = S_COLLECT;
          size_d      = 24'h0;
          half_d      = 1'b0;
          fall_pend_d = 1'b0;
          abort_d     = 1'b0;
        end
      end

      S_COLLECT: begin
        if (ioctl_wr) begin
          // a coincident falling edge waits until this byte is handled
          fall_pend_d = fall_pend_q | fall;
          size_d      = size_max;
          if (!ioctl_addr[0]) begin
            low_d      = ioctl_dout;
            half_d     = 1'b1;
            rom_addr_d = ioctl_addr[23:1];
          end else begin
            rom_din_d  = {ioctl_dout, half_q ? low_q : PAD_BYTE};
            rom_addr_d = ioctl_addr[23:1];
            rom_we_d   = 1'b1;
            rom_req_d  = ~rom_req_q;
            wait_d     = 1'b1;
            state_d    = S_WRITE_ROM;
          end
        end else if (fall | fall_pend_q) begin
          fall_pend_d = 1'b0;
          clr_d       = clear_en;
          if (half_q) begin
            rom_din_d = {PAD_BYTE, low_q};
            rom_we_d  = 1'b1;
            rom_req_d = ~rom_req_q;
            state_d   = S_FLUSH;
          end else if (clear_en) begin
            bs_addr_d = 19'h0;
            state_d   = S_CLEAR;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_WRITE_ROM: begin
        fall_pend_d = fall_pend_q | fall;
        if (rom_idle) begin
          wait_d   = 1'b0;
          half_d   = 1'b0;
          rom_we_d = 1'b0;
          state_d  = S_COLLECT;
        end
      end

      S_FLUSH: begin
        if (rom_idle) begin
          half_d   = 1'b0;
          rom_we_d = 1'b0;
          if (clr_q) begin
            bs_addr_d = 19'h0;
            state_d   = S_CLEAR;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_CLEAR: begin
        if (rise) begin
          state_d     = S_COLLECT;
          size_d      = 24'h0;
          half_d      = 1'b0;
          fall_pend_d = 1'b0;
          abort_d     = 1'b0;
        end else begin
          bs_din_d = CLEAR_FILL;
          bs_we_d  = 1'b1;
          bs_req_d = ~bs_req_q;
          state_d  = S_CLEAR_WAIT;
        end
      end

      S_CLEAR_WAIT: begin
        // a new download lets the outstanding write finish, then aborts
        abort_d = abort_q | rise;
        if (bs_idle) begin
          bs_we_d = 1'b0;
          if (abort_q | rise) begin
            state_d     = S_COLLECT;
            size_d      = 24'h0;
            half_d      = 1'b0;
            fall_pend_d = 1'b0;
            abort_d     = 1'b0;
          end else if (bs_addr_q == LAST_WORD) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            bs_addr_d = bs_addr_q + 19'd1;
            state_d   = S_CLEAR;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ioctl_wait    = wait_q;
  assign rom_addr      = rom_addr_q;
  assign rom_din       = rom_din_q;
  assign rom_we        = rom_we_q;
  assign rom_req       = rom_req_q;
  assign bsram_io_addr = bs_addr_q;
  assign bsram_io_din  = bs_din_q;
  assign bsram_io_we   = bs_we_q;
  assign bsram_io_req  = bs_req_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = done_q;
  assign rom_size      = size_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed download/fill sequences with a toggle-ack model
// and write scoreboards for the ROM and BSRAM ports.
module tb_rom_loader;

  localparam int CW = 4;
  localparam logic [7:0] PAD = 8'h00;

  typedef struct packed {
    logic [22:0] a;
    logic [15:0] d;
  } rw_t;

  logic        clk = 1'b0;
  logic        init_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [23:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        clear_en;
  logic [22:0] rom_addr;
  logic [15:0] rom_din;
  logic        rom_we;
  logic        rom_req;
  logic        rom_req_ack;
  logic [18:0] bsram_io_addr;
  logic [15:0] bsram_io_din;
  logic        bsram_io_we;
  logic        bsram_io_req;
  logic        bsram_io_req_ack;
  logic        busy;
  logic        done;
  logic [23:0] rom_size;

  rom_loader #(
    .CLEAR_WORDS(CW),
    .CLEAR_FILL (16'hFFFF),
    .PAD_BYTE   (PAD)
  ) dut (
    .clk             (clk),
    .init_n          (init_n),
    .ioctl_download  (ioctl_download),
    .ioctl_wr        (ioctl_wr),
    .ioctl_addr      (ioctl_addr),
    .ioctl_dout      (ioctl_dout),
    .ioctl_wait      (ioctl_wait),
    .clear_en        (clear_en),
    .rom_addr        (rom_addr),
    .rom_din         (rom_din),
    .rom_we          (rom_we),
    .rom_req         (rom_req),
    .rom_req_ack     (rom_req_ack),
    .bsram_io_addr   (bsram_io_addr),
    .bsram_io_din    (bsram_io_din),
    .bsram_io_we     (bsram_io_we),
    .bsram_io_req    (bsram_io_req),
    .bsram_io_req_ack(bsram_io_req_ack),
    .busy            (busy),
    .done            (done),
    .rom_size        (rom_size)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  rw_t         exp_rom[$];
  logic [18:0] exp_bs[$];

  bit          model_en;
  int          rom_lat, bs_lat;
  int          rom_cnt, bs_cnt;
  logic        rom_issue, bs_issue;
  int          done_cnt, rom_wr_cnt, bs_wr_cnt;
  bit          m_half;
  logic [7:0]  m_low;
  logic [22:0] m_even;

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    rw_t e;
    logic [18:0] ba;
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    if (model_en) begin
      if (rom_req !== rom_req_ack) begin
        if (rom_cnt == 0) begin
          rom_wr_cnt++;
          rom_issue = rom_req;
          checks++;
          assert (exp_rom.size() != 0) else begin
            errors++;
            $error("FAIL rom_extra_write observed=%0h@%0h expected=none",
                   rom_din, rom_addr);
          end
          if (exp_rom.size() != 0) begin
            e = exp_rom.pop_front();
            chk("rom_write", {rom_we, rom_addr, rom_din}, {1'b1, e.a, e.d});
          end
        end
        rom_cnt++;
        if (rom_cnt >= rom_lat) begin
          chk("rom_req_stable", rom_req, rom_issue);
          rom_req_ack = ~rom_req_ack;
          rom_cnt = 0;
        end
      end
      if (bsram_io_req !== bsram_io_req_ack) begin
        if (bs_cnt == 0) begin
          bs_wr_cnt++;
          bs_issue = bsram_io_req;
          checks++;
          assert (exp_bs.size() != 0) else begin
            errors++;
            $error("FAIL bs_extra_write observed=@%0h expected=none",
                   bsram_io_addr);
          end
          if (exp_bs.size() != 0) begin
            ba = exp_bs.pop_front();
            chk("bs_write", {bsram_io_we, bsram_io_addr, bsram_io_din},
                {1'b1, ba, 16'hFFFF});
          end
        end
        bs_cnt++;
        if (bs_cnt >= bs_lat) begin
          chk("bs_req_stable", bsram_io_req, bs_issue);
          bsram_io_req_ack = ~bsram_io_req_ack;
          bs_cnt = 0;
        end
      end
    end
  endtask

  task automatic send_byte(logic [23:0] a, logic [7:0] d);
    rw_t e;
    int n;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (!a[0]) begin
      m_low  = d;
      m_half = 1'b1;
      m_even = a[23:1];
    end else begin
      e.a = a[23:1];
      e.d = {d, m_half ? m_low : PAD};
      exp_rom.push_back(e);
      m_half = 1'b0;
    end
    tick();
    ioctl_wr = 1'b0;
    if (a[0]) begin
      chk("wait_set", ioctl_wait, 1);
      n = 0;
      while (ioctl_wait === 1'b1 && n < 200) begin
        n++;
        tick();
      end
      chk("wait_len", n, rom_lat);
    end
    tick();
    tick();
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_dl();
    rw_t e;
    ioctl_download = 1'b0;
    if (m_half) begin
      e.a = m_even;
      e.d = {PAD, m_low};
      exp_rom.push_back(e);
      m_half = 1'b0;
    end
    if (clear_en)
      for (int i = 0; i < CW; i++) exp_bs.push_back(19'(i));
  endtask

  task automatic wait_done(string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      n++;
      tick();
    end
    repeat (4) tick();
    chk(tag, done_cnt - d0, 1);
  endtask

  initial begin
    int n;
    int w0;
    int d0;
    init_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = 24'h0;
    ioctl_dout = 8'h00;
    clear_en = 1'b0;
    rom_req_ack = 1'b1;
    bsram_io_req_ack = 1'b0;
    model_en = 1'b0;
    rom_lat = 6;
    bs_lat = 3;
    rom_cnt = 0;
    bs_cnt = 0;
    done_cnt = 0;
    rom_wr_cnt = 0;
    bs_wr_cnt = 0;
    m_half = 1'b0;
    m_low = 8'h00;
    m_even = 23'h0;

    tick();
    tick();
    init_n = 1'b1;
    tick();
    chk("rst_rom_req", rom_req, 1);
    chk("rst_bs_req", bsram_io_req, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_size", rom_size, 0);
    chk("rst_we", {rom_we, bsram_io_we}, 0);
    chk("rst_rom_bus", {rom_addr, rom_din}, 0);
    chk("rst_bs_bus", {bsram_io_addr, bsram_io_din}, 0);

    model_en = 1'b1;
    repeat (100) tick();
    chk("idle_rom_ack", rom_req_ack, 1);
    chk("idle_bs_ack", bsram_io_req_ack, 0);
    chk("idle_writes", rom_wr_cnt + bs_wr_cnt, 0);

    w0 = rom_wr_cnt;
    start_dl();
    send_byte(24'd0, 8'h11);
    send_byte(24'd1, 8'h22);
    send_byte(24'd2, 8'h33);
    send_byte(24'd3, 8'h44);
    end_dl();
    wait_done("t1_done");
    chk("t1_size", rom_size, 4);
    chk("t1_nwr", rom_wr_cnt - w0, 2);
    chk("t1_q", exp_rom.size(), 0);
    chk("t1_busy", busy, 0);

    w0 = rom_wr_cnt;
    start_dl();
    chk("t2_size_clr", rom_size, 0);
    send_byte(24'd0, 8'hAA);
    send_byte(24'd1, 8'hBB);
    send_byte(24'd2, 8'hCC);
    end_dl();
    wait_done("t2_done");
    chk("t2_size", rom_size, 3);
    chk("t2_nwr", rom_wr_cnt - w0, 2);
    chk("t2_q", exp_rom.size(), 0);

    start_dl();
    send_byte(24'd1, 8'h5A);
    end_dl();
    wait_done("t3_done");
    chk("t3_size", rom_size, 2);
    chk("t3_q", exp_rom.size(), 0);

    clear_en = 1'b1;
    w0 = bs_wr_cnt;
    start_dl();
    send_byte(24'd0, 8'h01);
    send_byte(24'd1, 8'h02);
    end_dl();
    wait_done("t4_done");
    chk("t4_nbs", bs_wr_cnt - w0, CW);
    chk("t4_bsq", exp_bs.size(), 0);
    chk("t4_size", rom_size, 2);

    bs_lat = 10;
    w0 = bs_wr_cnt;
    d0 = done_cnt;
    start_dl();
    send_byte(24'd0, 8'h01);
    send_byte(24'd1, 8'h02);
    end_dl();
    n = 0;
    while (!(bsram_io_req !== bsram_io_req_ack && bsram_io_addr == 19'd2)
           && n < 500) begin
      n++;
      tick();
    end
    chk("t5_at_addr2", bsram_io_addr, 2);
    ioctl_download = 1'b1;
    void'(exp_bs.pop_back());
    n = 0;
    while (bsram_io_req !== bsram_io_req_ack && n < 100) begin
      n++;
      tick();
    end
    repeat (30) tick();
    chk("t5_nbs", bs_wr_cnt - w0, 3);
    chk("t5_bsq", exp_bs.size(), 0);
    chk("t5_size", rom_size, 0);
    chk("t5_busy", busy, 1);
    chk("t5_no_done", done_cnt - d0, 0);
    clear_en = 1'b0;
    send_byte(24'd0, 8'h77);
    send_byte(24'd1, 8'h88);
    end_dl();
    wait_done("t5_done");
    chk("t5_size2", rom_size, 2);
    chk("t5_q", exp_rom.size(), 0);

    rom_lat = 20;
    start_dl();
    send_byte(24'd0, 8'h10);
    begin
      rw_t e;
      e.a = 23'd0;
      e.d = 16'h2010;
      exp_rom.push_back(e);
      m_half = 1'b0;
    end
    ioctl_addr = 24'd1;
    ioctl_dout = 8'h20;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("t6_wait", ioctl_wait, 1);
    tick();
    tick();
    chk("t6_busy", busy, 1);
    init_n = 1'b0;
    ioctl_download = 1'b0;
    model_en = 1'b0;
    tick();
    chk("t6_rst_wait", ioctl_wait, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_req", rom_req, rom_req_ack);
    chk("t6_rst_size", rom_size, 0);
    rom_cnt = 0;
    init_n = 1'b1;
    model_en = 1'b1;
    repeat (5) tick();
    chk("t6_q", exp_rom.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
